// File: rtl/adder_pkg.sv
// Shared constants and helpers for the chunked pipelined adder.
package adder_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_CHUNK = 2;

   // Pipeline depth: one stage per CHUNK-bit slice of the operands.
   function automatic int calc_stages(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice with carry-in and carry-out; holds no state.
module adder_chunk
   import adder_pkg::*;
#(
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   input  logic             i_cin,
   output logic [CHUNK-1:0] o_sum,
   output logic             o_cout
);

   logic [CHUNK:0] w_total;

   assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
   assign o_sum   = w_total[CHUNK-1:0];
   assign o_cout  = w_total[CHUNK];

endmodule

// File: rtl/adder_pipe.sv
// Valid/ready pipelined adder/subtractor: one CHUNK-bit slice is resolved per
// stage, with the operands skewed forward alongside the partial result.
module adder_pipe
   import adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum
);

   localparam int STAGES = calc_stages(WIDTH, CHUNK);
   localparam logic [WIDTH-1:0] L_MASK = WIDTH'({CHUNK{1'b1}});

   // Reject configurations that cannot be split into whole slices.
   generate
      if (CHUNK < 1) begin : g_bad_chunk
         $error("adder_pipe: CHUNK must be at least 1");
      end else if ((WIDTH % CHUNK) != 0) begin : g_bad_split
         $error("adder_pipe: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   // Stage registers: operand skew (a, effective b), partial sum, carry, valid.
   logic [WIDTH-1:0] r_a [STAGES];
   logic [WIDTH-1:0] r_b [STAGES];
   logic [WIDTH-1:0] r_s [STAGES];
   logic             r_c [STAGES];
   logic             r_v [STAGES];

   // Next-state values produced by each stage.
   logic [WIDTH-1:0] w_a_nxt [STAGES];
   logic [WIDTH-1:0] w_b_nxt [STAGES];
   logic [WIDTH-1:0] w_s_nxt [STAGES];
   logic             w_c_nxt [STAGES];
   logic             w_v_nxt [STAGES];

   logic w_en;

   // The whole pipeline moves as one unless the output is held by the consumer.
   assign w_en      = !r_v[STAGES-1] || out_ready;
   assign in_ready  = w_en;
   assign out_valid = r_v[STAGES-1];
   assign sum       = {r_c[STAGES-1], r_s[STAGES-1]};

   generate
      for (genvar g = 0; g < STAGES; g++) begin : g_stage
         logic [WIDTH-1:0] w_a_in;
         logic [WIDTH-1:0] w_b_in;
         logic [WIDTH-1:0] w_s_in;
         logic             w_c_in;
         logic             w_v_in;
         logic [CHUNK-1:0] w_cs;
         logic             w_co;

         if (g == 0) begin : g_head
            // Subtraction is a + ~b + 1: invert b here and seed the carry with sub.
            assign w_a_in = a;
            assign w_b_in = sub ? ~b : b;
            assign w_s_in = {WIDTH{1'b0}};
            assign w_c_in = sub;
            assign w_v_in = in_valid;
         end else begin : g_tail
            assign w_a_in = r_a[g-1];
            assign w_b_in = r_b[g-1];
            assign w_s_in = r_s[g-1];
            assign w_c_in = r_c[g-1];
            assign w_v_in = r_v[g-1];
         end

         adder_chunk #(
            .CHUNK(CHUNK)
         ) u_chunk (
            .i_a    (w_a_in[g*CHUNK +: CHUNK]),
            .i_b    (w_b_in[g*CHUNK +: CHUNK]),
            .i_cin  (w_c_in),
            .o_sum  (w_cs),
            .o_cout (w_co)
         );

         // Slice g of the result is inserted; lower slices pass through untouched.
         assign w_a_nxt[g] = w_a_in;
         assign w_b_nxt[g] = w_b_in;
         assign w_s_nxt[g] = (w_s_in & ~(L_MASK << (g*CHUNK)))
                           | (WIDTH'(w_cs) << (g*CHUNK));
         assign w_c_nxt[g] = w_co;
         assign w_v_nxt[g] = w_v_in;
      end
   endgenerate

   // Pipeline registers: cleared by reset, advanced together on enable, held otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= {WIDTH{1'b0}};
            r_b[k] <= {WIDTH{1'b0}};
            r_s[k] <= {WIDTH{1'b0}};
            r_c[k] <= 1'b0;
            r_v[k] <= 1'b0;
         end
      end else if (w_en) begin
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= w_a_nxt[k];
            r_b[k] <= w_b_nxt[k];
            r_s[k] <= w_s_nxt[k];
            r_c[k] <= w_c_nxt[k];
            r_v[k] <= w_v_nxt[k];
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= r_a[k];
            r_b[k] <= r_b[k];
            r_s[k] <= r_s[k];
            r_c[k] <= r_c[k];
            r_v[k] <= r_v[k];
         end
      end
   end

endmodule

// File: tb/tb_adder_pipe.sv
// Self-checking bench for adder_pipe (WIDTH=8, CHUNK=2): scoreboard of expected
// sums plus per-scenario directed checks.
module tb_adder_pipe;

   localparam int WIDTH  = 8;
   localparam int CHUNK  = 2;
   localparam int STAGES = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   sum;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   int out_cnt  = 0;
   logic [WIDTH:0] sb_q [$];

   adder_pipe #(
      .WIDTH(WIDTH),
      .CHUNK(CHUNK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] fa,
                                              input logic [WIDTH-1:0] fb,
                                              input logic fs);
      logic [WIDTH-1:0] nb;
      logic [WIDTH:0]   r;
      nb = ~fb;
      if (fs) r = {1'b0, fa} + {1'b0, nb} + 9'd1;
      else    r = {1'b0, fa} + {1'b0, fb};
      return r;
   endfunction

   // Scoreboard: sample just before the rising edge, push accepted beats, pop and compare emitted sums.
   always @(negedge clk) begin
      logic [WIDTH:0] exp_v;
      #4;
      if (rst) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            out_cnt++;
            chk_cnt++;
            if (sb_q.size() == 0) begin
               $display("FAIL sb_unexpected: got sum=%h with no beat outstanding", sum);
            end else begin
               exp_v = sb_q.pop_front();
               if (sum !== exp_v) $display("FAIL sb_sum: got %h want %h", sum, exp_v);
               else pass_cnt++;
            end
         end
         if (in_valid && in_ready) sb_q.push_back(ref_sum(a, b, sub));
      end
   end

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk_cnt++;
      if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid);
      else pass_cnt++;
      chk_cnt++;
      if (sum !== 9'h000) $display("FAIL rst_sum: got %h want 000", sum);
      else pass_cnt++;
      rst = 1'b0;
      #1;
      chk_cnt++;
      if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready);
      else pass_cnt++;
   endtask

   task automatic test_add_carry();
      int lat;
      @(negedge clk);
      out_ready = 1'b1; a = 8'hFF; b = 8'h01; sub = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      chk_cnt++;
      if (lat !== STAGES) $display("FAIL add_latency: got %0d want %0d", lat, STAGES);
      else pass_cnt++;
      chk_cnt++;
      if (sum !== 9'h100) $display("FAIL add_carry_sum: got %h want 100", sum);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_sub();
      int n;
      @(negedge clk);
      out_ready = 1'b1; a = 8'h05; b = 8'h07; sub = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      a = 8'h07; b = 8'h05;
      @(negedge clk);
      in_valid = 1'b0; sub = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk_cnt++;
      if ({out_valid, sum} !== {1'b1, 9'h0FE}) $display("FAIL sub_borrow: got v=%b sum=%h want v=1 sum=0fe", out_valid, sum);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if ({out_valid, sum} !== {1'b1, 9'h102}) $display("FAIL sub_noborrow: got v=%b sum=%h want v=1 sum=102", out_valid, sum);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               a = 8'(i); b = 8'(i * 16); sub = 1'b0; in_valid = 1'b1;
            end
            @(negedge clk);
            in_valid = 1'b0;
         end
         begin
            int n;
            logic [WIDTH:0] e;
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 30) begin
               @(negedge clk);
               n++;
            end
            for (int j = 0; j < 8; j++) begin
               e = 9'(j * 17);
               chk_cnt++;
               if ({out_valid, sum} !== {1'b1, e}) $display("FAIL b2b_beat%0d: got v=%b sum=%h want v=1 sum=%h", j, out_valid, sum, e);
               else pass_cnt++;
               @(negedge clk);
            end
         end
      join
   endtask

   task automatic test_stall();
      int acc;
      int base;
      logic took;
      logic [WIDTH:0] held;
      held = 9'h000;
      @(negedge clk);
      out_ready = 1'b0; sub = 1'b0; b = 8'h03; a = 8'h30; in_valid = 1'b1;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         #1;
         took = in_ready;
         @(negedge clk);
         if (took) begin
            acc++;
            a = 8'h30 + 8'(acc);
         end
         if (c == 4) held = sum;
      end
      #1;
      chk_cnt++;
      if (acc !== 4) $display("FAIL stall_accepted: got %0d want 4", acc);
      else pass_cnt++;
      chk_cnt++;
      if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", in_ready);
      else pass_cnt++;
      chk_cnt++;
      if (sum !== 9'h033 || sum !== held) $display("FAIL stall_sum_hold: got %h (earlier %h) want 033", sum, held);
      else pass_cnt++;
      in_valid = 1'b0;
      out_ready = 1'b1;
      base = out_cnt;
      repeat (4) @(negedge clk);
      #1;
      chk_cnt++;
      if (out_cnt - base !== 4) $display("FAIL stall_drain_count: got %0d want 4", out_cnt - base);
      else pass_cnt++;
      chk_cnt++;
      if ({out_valid, in_ready} !== 2'b01) $display("FAIL stall_after_drain: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int base;
      int seen;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a = 8'h40 + 8'(i); b = 8'h11; sub = (i == 1); in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if ({out_valid, sum} !== {1'b0, 9'h000}) $display("FAIL midrst_clear: got v=%b sum=%h want v=0 sum=000", out_valid, sum);
      else pass_cnt++;
      rst = 1'b0;
      #1;
      chk_cnt++;
      if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b want 1", in_ready);
      else pass_cnt++;
      base = out_cnt;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk_cnt++;
      if (seen !== 0 || out_cnt !== base) $display("FAIL midrst_stale: got %0d valid cycles, %0d outputs want 0", seen, out_cnt - base);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int sent;
      int cyc;
      int base;
      int n;
      logic pending;
      sent = 0; cyc = 0; pending = 1'b0;
      base = out_cnt;
      @(negedge clk);
      while (sent < 10000 && cyc < 60000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         if (!pending) begin
            if ($urandom_range(0, 4) != 0) begin
               a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
               in_valid = 1'b1;
               pending = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
         end
         #1;
         if (in_valid && in_ready) begin
            sent++;
            pending = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (sb_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk_cnt++;
      if (sent !== 10000) $display("FAIL rand_sent: got %0d want 10000", sent);
      else pass_cnt++;
      chk_cnt++;
      if (sb_q.size() !== 0) $display("FAIL rand_leftover: got %0d outstanding want 0", sb_q.size());
      else pass_cnt++;
      chk_cnt++;
      if (out_cnt - base !== sent) $display("FAIL rand_out_count: got %0d want %0d", out_cnt - base, sent);
      else pass_cnt++;
   endtask

   // Global time limit so a stuck pipeline cannot hang the run.
   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "time limit reached");
   end

   // Scenario sequence.
   initial begin
      rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0; out_ready = 1'b0;
      test_reset();
      test_add_carry();
      test_sub();
      test_back_to_back();
      test_stall();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
